uart_tx_arbiter: RTL and testbench

Parametrised arbiter that shares the single `uart_tx` transmitter among `NUM_CH` byte producers, such as the matrix printers of the input, generate, display and calculate modes. It replaces the fixed mode-indexed combinational TX mux in the top level. Each producer owns the line for a whole message, so bytes from different producers never interleave. A watchdog reclaims the line from a producer that stalls mid-message.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_picker.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the arbiter FSM state encoding and the default byte width.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

endpackage : uart_pkg

// File: rtl/rr_picker.sv
// One-hot request selector, reusable by any arbiter.
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - first index searched when mode=1 (round robin); the search wraps
//   mode - 0: lowest set index wins, 1: first set index at or after ptr wins
//   win  - one-hot winner, all zero when req is empty
module rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     win
);

    logic             found;
    int unsigned      pos;
    logic [IDX_W-1:0] sel;

    // Walk all N positions from the search origin and keep the first hit.
    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = mode ? ((32'(ptr) + i) % N) : i;
            sel = IDX_W'(pos);
            if (!found && req[sel]) begin
                win[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx transmitter among NUM_CH byte producers. A producer
// owns the line for a whole message (while its ch_req is high), so bytes of
// different producers never interleave. A watchdog reclaims the line from
// an owner that stays idle for TIMEOUT cycles and locks it out until it
// drops its request.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   ch_req        - per-channel message request (held for the whole message)
//   ch_start      - per-channel one-cycle byte-send pulse
//   ch_data       - per-channel byte, channel i at [i*DATA_W +: DATA_W]
//   ch_busy       - per-channel busy (replaces uart_tx's tx_busy)
//   uart_tx_busy  - busy from uart_tx
//   uart_tx_en    - registered send pulse to uart_tx
//   uart_tx_data  - registered byte to uart_tx
//   grant         - one-hot owner, zero when nobody owns the line
//   timeout_err   - one-cycle pulse on forced release
//   timeout_ch    - index of the last timed-out channel
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = UART_DATA_W,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 50_000_000,
    parameter int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_start,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_busy,
    input  logic                     uart_tx_busy,
    output logic                     uart_tx_en,
    output logic [DATA_W-1:0]        uart_tx_data,
    output logic [NUM_CH-1:0]        grant,
    output logic                     timeout_err,
    output logic [IDX_W-1:0]         timeout_ch
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic             RR_MODE  = (ARB_MODE == 1) ? 1'b1 : 1'b0;

    arb_state_e          state_q,   state_d;
    logic [NUM_CH-1:0]   grant_q,   grant_d;
    logic [IDX_W-1:0]    gidx_q,    gidx_d;
    logic [IDX_W-1:0]    last_q,    last_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [NUM_CH-1:0]   lockout_q, lockout_d;
    logic                tx_en_q,   tx_en_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                terr_q,    terr_d;
    logic [IDX_W-1:0]    tch_q,     tch_d;

    logic [NUM_CH-1:0]   eligible;
    logic [IDX_W-1:0]    start_ptr;
    logic [NUM_CH-1:0]   win;
    logic [IDX_W-1:0]    win_idx;
    logic                own_req;
    logic                own_start;
    logic [DATA_W-1:0]   own_data;

    // Locked-out channels are invisible to arbitration until they drop ch_req.
    assign eligible  = ch_req & ~lockout_q;
    // Round-robin search begins just after the last owner, wrapping to 0.
    assign start_ptr = (last_q == IDX_LAST) ? '0 : last_q + 1'b1;

    rr_picker #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (eligible),
        .ptr  (start_ptr),
        .mode (RR_MODE),
        .win  (win)
    );

    // One-hot winner to index.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (win[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Owner's request, start pulse and byte.
    assign own_req   = ch_req[gidx_q];
    assign own_start = ch_start[gidx_q];
    assign own_data  = ch_data[32'(gidx_q) * DATA_W +: DATA_W];

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        lockout_d = lockout_q & ch_req;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        terr_d    = 1'b0;
        tch_d     = tch_q;

        case (state_q)
            ARB_IDLE: begin
                if (|eligible) begin
                    state_d = ARB_OWN;
                    grant_d = win;
                    gidx_d  = win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                end
            end

            ARB_OWN: begin
                // A byte is forwarded even in the cycle the owner releases.
                if (own_start) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = own_data;
                end
                if (!own_req) begin
                    state_d = ARB_DRAIN;
                    grant_d = '0;
                end else if (own_start) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d            = 1'b1;
                    tch_d             = gidx_q;
                    lockout_d[gidx_q] = 1'b1;
                    state_d           = ARB_DRAIN;
                    grant_d           = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ARB_DRAIN: begin
                // Wait for the last byte to leave uart_tx before re-arbitrating.
                if (!tx_en_q && !uart_tx_busy) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IDX_LAST;
            cnt_q     <= '0;
            lockout_q <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            terr_q    <= 1'b0;
            tch_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            lockout_q <= lockout_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            terr_q    <= terr_d;
            tch_q     <= tch_d;
        end
    end

    // Owner sees busy from uart_tx, plus the cycle before uart_tx raises it;
    // everybody else is held off.
    always_comb begin
        ch_busy = '1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (state_q == ARB_OWN && grant_q[i]) begin
                ch_busy[i] = uart_tx_busy | tx_en_q;
            end
        end
    end

    assign grant        = grant_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign timeout_err  = terr_q;
    assign timeout_ch   = tch_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a fixed-priority instance (a_*) and a
// round-robin instance (b_*), both with a 16-cycle watchdog.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  a_req = '0, a_start = '0;
    logic [31:0] a_data = '0;
    logic        a_busy = 1'b0;
    logic [3:0]  a_ch_busy, a_grant;
    logic        a_en, a_terr;
    logic [7:0]  a_dout;
    logic [1:0]  a_tch;

    logic [3:0]  b_req = '0, b_start = '0;
    logic [31:0] b_data = '0;
    logic        b_busy = 1'b0;
    logic [3:0]  b_ch_busy, b_grant;
    logic        b_en, b_terr;
    logic [7:0]  b_dout;
    logic [1:0]  b_tch;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int         a_en_cnt = 0;
    logic [7:0] a_seen[$];
    logic       a_ff_seen = 1'b0;

    uart_tx_arbiter #(
        .NUM_CH(4), .DATA_W(8), .ARB_MODE(0), .TIMEOUT(16)
    ) u_fp (
        .clk(clk), .rst_n(rst_n),
        .ch_req(a_req), .ch_start(a_start), .ch_data(a_data),
        .ch_busy(a_ch_busy), .uart_tx_busy(a_busy),
        .uart_tx_en(a_en), .uart_tx_data(a_dout),
        .grant(a_grant), .timeout_err(a_terr), .timeout_ch(a_tch)
    );

    uart_tx_arbiter #(
        .NUM_CH(4), .DATA_W(8), .ARB_MODE(1), .TIMEOUT(16)
    ) u_rr (
        .clk(clk), .rst_n(rst_n),
        .ch_req(b_req), .ch_start(b_start), .ch_data(b_data),
        .ch_busy(b_ch_busy), .uart_tx_busy(b_busy),
        .uart_tx_en(b_en), .uart_tx_data(b_dout),
        .grant(b_grant), .timeout_err(b_terr), .timeout_ch(b_tch)
    );

    always #5 clk = ~clk;

    // Record every byte sent by the fixed-priority instance.
    always @(negedge clk) begin
        if (a_en) begin
            a_en_cnt++;
            a_seen.push_back(a_dout);
            if (a_dout == 8'hFF) a_ff_seen = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Owner `ch` sends one byte on instance A; uart_tx is busy for 3 cycles.
    task automatic send_a(input int ch, input logic [7:0] b);
        a_data[ch*8 +: 8] = b;
        a_start[ch] = 1'b1;
        tick();
        a_start = '0;
        chk("send_en", 32'(a_en), 32'd1);
        chk("send_data", 32'(a_dout), 32'(b));
        chk("busy_gap", 32'(a_ch_busy[ch]), 32'd1);
        a_busy = 1'b1;
        tick(); tick(); tick();
        a_busy = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        int exp_ch;
        bit seen_grant;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_grant", 32'(a_grant), 32'h0);
        chk("rst_en", 32'(a_en), 32'h0);
        chk("rst_data", 32'(a_dout), 32'h0);
        chk("rst_terr", 32'(a_terr), 32'h0);
        chk("rst_tch", 32'(a_tch), 32'h0);
        chk("rst_busy", 32'(a_ch_busy), 32'hF);
        rst_n = 1'b1;
        tick();

        // Basic ownership: ch2 sends 31 0D 0A
        base = a_en_cnt;
        a_req = 4'b0100;
        tick();
        chk("basic_grant", 32'(a_grant), 32'h4);
        chk("basic_busy", 32'(a_ch_busy), 32'hB);
        send_a(2, 8'h31);
        send_a(2, 8'h0D);
        send_a(2, 8'h0A);
        a_req = '0;
        tick();
        chk("basic_release", 32'(a_grant), 32'h0);
        tick();
        chk("basic_count", 32'(a_en_cnt - base), 32'd3);
        chk("basic_b0", 32'(a_seen[base]), 32'h31);
        chk("basic_b1", 32'(a_seen[base+1]), 32'h0D);
        chk("basic_b2", 32'(a_seen[base+2]), 32'h0A);

        // Fixed priority: ch1 beats ch3; ch3 waits for drain
        a_req = 4'b1010;
        tick();
        chk("fp_grant1", 32'(a_grant), 32'h2);
        chk("fp_busy3", 32'(a_ch_busy[3]), 32'd1);
        send_a(1, 8'h41);
        chk("fp_busy3_mid", 32'(a_ch_busy[3]), 32'd1);
        a_req = 4'b1000;
        a_busy = 1'b1;
        tick();
        chk("fp_drain_grant", 32'(a_grant), 32'h0);
        chk("fp_drain_busy", 32'(a_ch_busy), 32'hF);
        tick(); tick();
        chk("fp_drain_hold", 32'(a_grant), 32'h0);
        a_busy = 1'b0;
        tick();
        chk("fp_idle", 32'(a_grant), 32'h0);
        tick();
        chk("fp_grant3", 32'(a_grant), 32'h8);
        a_req = '0;
        tick(); tick();

        // Non-owner isolation: ch0 owns, ch2 pulses 0xFF
        a_req = 4'b0001;
        tick();
        chk("iso_grant", 32'(a_grant), 32'h1);
        a_data[23:16] = 8'hFF;
        a_start = 4'b0100;
        tick();
        a_start = '0;
        chk("iso_no_en", 32'(a_en), 32'h0);
        send_a(0, 8'h55);
        chk("iso_no_ff", 32'(a_ff_seen), 32'h0);
        a_req = '0;
        tick(); tick();

        // Timeout: ch1 sends nothing, ch0 waits
        a_req = 4'b0010;
        tick();
        chk("to_grant", 32'(a_grant), 32'h2);
        a_req = 4'b0011;
        repeat (15) tick();
        chk("to_not_yet", 32'(a_terr), 32'h0);
        chk("to_still_own", 32'(a_grant), 32'h2);
        tick();
        chk("to_err", 32'(a_terr), 32'h1);
        chk("to_ch", 32'(a_tch), 32'h1);
        chk("to_release", 32'(a_grant), 32'h0);
        tick();
        chk("to_pulse_once", 32'(a_terr), 32'h0);
        tick();
        chk("to_ch0_grant", 32'(a_grant), 32'h1);
        chk("to_ch_hold", 32'(a_tch), 32'h1);
        a_req = 4'b0010;
        tick(); tick(); tick();
        chk("to_lockout", 32'(a_grant), 32'h0);
        tick();
        chk("to_lockout2", 32'(a_grant), 32'h0);
        a_req = '0;
        tick();
        a_req = 4'b0010;
        tick();
        chk("to_unlock", 32'(a_grant), 32'h2);

        // Reset mid-message with uart_tx busy
        a_req = '0;
        tick(); tick();
        a_req = 4'b0100;
        tick();
        chk("mr_grant", 32'(a_grant), 32'h4);
        a_data[23:16] = 8'h77;
        a_start = 4'b0100;
        tick();
        a_start = '0;
        chk("mr_en", 32'(a_en), 32'h1);
        a_busy = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("mr_grant0", 32'(a_grant), 32'h0);
        chk("mr_en0", 32'(a_en), 32'h0);
        chk("mr_busy", 32'(a_ch_busy), 32'hF);
        chk("mr_tch", 32'(a_tch), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mr_idle_regrant", 32'(a_grant), 32'h4);
        a_busy = 1'b0;
        a_req = '0;

        // Round robin: all hold req; owner drops req in its byte's cycle
        b_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ch = k % 4;
            seen_grant = 1'b0;
            for (int w = 0; w < 10 && !seen_grant; w++) begin
                if (b_grant != 4'b0) seen_grant = 1'b1;
                else tick();
            end
            chk("rr_grant", 32'(b_grant), 32'(1) << exp_ch);
            b_data[exp_ch*8 +: 8] = 8'(8'h60 + k);
            b_start[exp_ch] = 1'b1;
            b_req[exp_ch] = 1'b0;
            tick();
            b_start = '0;
            b_req[exp_ch] = 1'b1;
            chk("rr_en", 32'(b_en), 32'h1);
            chk("rr_data", 32'(b_dout), 32'(8'h60 + k));
            chk("rr_release", 32'(b_grant), 32'h0);
        end
        b_req = '0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
